// File: rtl/arb_pkg.sv
// Shared types and the wrap-around priority finder for the valid/ready arbiter family.
package arb_pkg;

  typedef enum logic {ARB_FP = 1'b0, ARB_RR = 1'b1} arb_mode_e;
  typedef enum logic {HSK_PASS = 1'b0, HSK_REG = 1'b1} hsk_mode_e;

  localparam int unsigned ARB_MAX_W = 32;
  localparam int unsigned ARB_IDX_W = 5;

  // Index of the first set bit of vec at or after start, wrapping at width; -1 when empty.
  function automatic int first_set_from(input logic [ARB_MAX_W-1:0] vec,
                                        input int unsigned          width,
                                        input int unsigned          start);
    int                   found;
    int unsigned          idx;
    logic [ARB_IDX_W-1:0] bit_sel;
    found = -1;
    for (int unsigned k = 0; k < ARB_MAX_W; k++) begin
      idx = start + k;
      if (idx >= width) idx = idx - width;
      bit_sel = ARB_IDX_W'(idx);
      if (k < width && found < 0 && vec[bit_sel]) found = int'(idx);
    end
    return found;
  endfunction

endpackage

// File: rtl/arb_rr_sel.sv
// Combinational selector: request vector plus round-robin pointer to a one-hot grant.
module arb_rr_sel
  import arb_pkg::*;
#(
  parameter int  MODE  = 1,
  parameter int  WIDTH = 4,
  localparam int PTR_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [WIDTH-1:0] grant
);

  logic [ARB_MAX_W-1:0] req_ext;
  int unsigned          start;
  int                   win;

  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    req_ext            = '0;
    grant              = '0;
    req_ext[WIDTH-1:0] = req;
    start              = (MODE == int'(ARB_RR)) ? 32'(rr_ptr) : 32'd0;
    win                = first_set_from(req_ext, WIDTH, start);
    if (win >= 0) grant = WIDTH'(1'b1) << win;
  end

endmodule

// File: rtl/cmn_real_mux_onehot.sv
// AND-OR multiplexer driven by a one-hot (or all-zero) select; zero select yields zero.
module cmn_real_mux_onehot #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic [N-1:0]  sel,
  input  logic [DW-1:0] din [N],
  output logic [DW-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) dout = dout | (din[i] & {DW{sel[i]}});
  end

endmodule

// File: rtl/arb_vrp_rr.sv
// N:1 valid/ready arbiter with packet lock, fixed-priority or round-robin selection,
// and either a pass-through or a one-entry registered output.
module arb_vrp_rr
  import arb_pkg::*;
#(
  parameter int               MODE      = 1,
  parameter int               HSK_MODE  = 1,
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] PRIORITY  = {WIDTH{1'b1}},
  parameter int               PLD_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     v_vld_s,
  output logic [WIDTH-1:0]     v_rdy_s,
  input  logic [PLD_WIDTH-1:0] v_pld_s [WIDTH],
  input  logic [WIDTH-1:0]     v_last_s,
  output logic                 vld_m,
  input  logic                 rdy_m,
  output logic [PLD_WIDTH-1:0] pld_m,
  output logic                 last_m,
  output logic [WIDTH-1:0]     grant_m
);

  localparam int PTR_W  = $clog2(WIDTH);
  localparam int BEAT_W = PLD_WIDTH + 1;
  localparam bit REG_SLOT = (HSK_MODE == int'(HSK_REG));

  logic [WIDTH-1:0]  req, sel_grant, grant, lock_vec;
  logic              lock, acc, granted_last, stall_set;
  logic [PTR_W-1:0]  rr_ptr, granted_idx, next_ptr;
  logic [BEAT_W-1:0] beat_in [WIDTH];
  logic [BEAT_W-1:0] beat_sel;

  assign req = v_vld_s & PRIORITY;

  arb_rr_sel #(.MODE(MODE), .WIDTH(WIDTH)) u_sel (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (sel_grant)
  );

  // While a packet or a stalled beat owns the output, the choice is frozen.
  assign grant = lock ? lock_vec : sel_grant;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) beat_in[i] = {v_last_s[i], v_pld_s[i]};
  end

  cmn_real_mux_onehot #(.N(WIDTH), .DW(BEAT_W)) u_mux (
    .sel  (grant),
    .din  (beat_in),
    .dout (beat_sel)
  );

  assign granted_last = beat_sel[PLD_WIDTH];
  assign acc          = |(v_vld_s & v_rdy_s);

  always_comb begin
    granted_idx = '0;
    for (int i = 0; i < WIDTH; i++) if (grant[i]) granted_idx = PTR_W'(i);
    next_ptr = (granted_idx == PTR_W'(WIDTH - 1)) ? '0 : granted_idx + PTR_W'(1);
  end

  generate
    if (REG_SLOT) begin : g_reg
      logic                 out_vld, out_last, slot_free;
      logic [PLD_WIDTH-1:0] out_pld;
      logic [WIDTH-1:0]     out_grant;

      assign slot_free = !out_vld || rdy_m;
      assign v_rdy_s   = grant & {WIDTH{slot_free}};
      assign stall_set = 1'b0;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_vld   <= 1'b0;
          out_pld   <= '0;
          out_last  <= 1'b0;
          out_grant <= '0;
        end else if (acc) begin
          out_vld   <= 1'b1;
          out_pld   <= beat_sel[PLD_WIDTH-1:0];
          out_last  <= granted_last;
          out_grant <= grant;
        end else if (rdy_m) begin
          out_vld   <= 1'b0;
        end
      end

      assign vld_m   = out_vld;
      assign pld_m   = out_pld;
      assign last_m  = out_last;
      assign grant_m = out_grant & {WIDTH{out_vld}};
    end else begin : g_pass
      assign v_rdy_s   = grant & {WIDTH{rdy_m}};
      assign vld_m     = |(grant & v_vld_s);
      assign pld_m     = beat_sel[PLD_WIDTH-1:0];
      assign last_m    = granted_last;
      assign grant_m   = grant & v_vld_s;
      assign stall_set = vld_m && !rdy_m && !lock;
    end
  endgenerate

  // NOTE: rst_n is sampled on the clock edge; non-blocking assignments keep every flop
  // reading pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock     <= 1'b0;
      lock_vec <= '0;
      rr_ptr   <= '0;
    end else if (acc) begin
      if (granted_last) begin
        lock   <= 1'b0;
        rr_ptr <= next_ptr;
      end else begin
        lock     <= 1'b1;
        lock_vec <= grant;
      end
    end else if (stall_set) begin
      lock     <= 1'b1;
      lock_vec <= grant;
    end
  end

  // A locked source must keep valid until its last beat; outputs stay one-hot and stable.
  a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(v_rdy_s));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_m));
  a_lock_vld:   assert property (@(posedge clk) disable iff (!rst_n) lock |-> |(v_vld_s & lock_vec));
  a_pld_stable: assert property (@(posedge clk) disable iff (!rst_n)
                                 (vld_m && !rdy_m) |=> $stable(pld_m));

endmodule
